sm_mcu_cpu_mul_seq: RTL and testbench
=====================================

# sm_mcu_cpu_mul_seq

Two-pass multiply sequencer directly upstream of the CPU's 32x16 multiply cell. It accepts a 32x32 multiply request and drives the cell twice: first with the low half of operand 2, then with the high half. It accumulates the partial products into the low 32 bits of the full product and returns that with a one-cycle done pulse. The low 32 bits are identical for signed and unsigned operands, so the block has no sign control.

## Interface
Parameters:
- CELL_LAT, 1: cycles from stable cell operands to valid `mul_cell_result`; legal range 1..3.
- DATA_W, 32: operand/result width; fixed, not overridable.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; accepted only while `busy`=0.
- src1  in  32  multiplicand; sampled on the accepted start.
- src2  in  32  multiplier; sampled on the accepted start.
- busy  out  1  high from the cycle after acceptance until the completion cycle.
- done  out  1  one-cycle pulse; `result` is valid.
- result  out  32  low 32 bits of src1*src2; held until next completion.
- mul_src1  out  32  to cell operand A.
- mul_src2  out  32  to cell operand B; cell uses [15:0] only.
- mul_cell_result  in  32  cell output: (mul_src1 * mul_src2[15:0]) mod 2^32.

## Operation
- Registers: op1_q, op2_q (32 each), acc_q (32), cnt_q (2 bits), state_q, result, done.
- States:
  - IDLE: on start, latch src1/src2 into op1_q/op2_q, clear cnt_q, go to LO.
  - LO: drive mul_src1=op1_q, mul_src2={16'h0, op2_q[15:0]}. cnt_q increments each cycle. When cnt_q==CELL_LAT: acc_q <= mul_cell_result, cnt_q <= 0, go to HI.
  - HI: drive mul_src1=op1_q, mul_src2={16'h0, op2_q[31:16]}. When cnt_q==CELL_LAT: result <= acc_q + {mul_cell_result[15:0], 16'h0} (mod 2^32), done <= 1, go to IDLE.
- In IDLE, mul_src1/mul_src2 hold their last driven values; no toggling is required.
- `busy` = (state_q != IDLE).
- A start while busy is ignored; no queueing and no error flag.
- Reset (any state, including mid-operation): state IDLE, busy 0, done 0, result 0, acc_q 0, cnt_q 0, op1_q/op2_q 0. A cell result arriving after reset is discarded.

## Timing
- Cycle 0: start sampled in IDLE.
- Cycles 1..1+CELL_LAT: LO. Capture in cycle 1+CELL_LAT.
- Cycles 2+CELL_LAT..2+2*CELL_LAT: HI.
- Cycle 3+2*CELL_LAT: done=1, busy=0, result valid. With CELL_LAT=1, done is at cycle 5.
- Start in the done cycle is accepted; back-to-back throughput is one op per 3+2*CELL_LAT cycles.
- Operands to the cell are stable for the whole of each pass. No assumption is made on cell pipeline depth beyond CELL_LAT.

## Configuration
- SM_MCU_MUL_SHORTCUT_EN defined: at the LO capture, if op2_q[31:16]==0, then result <= mul_cell_result, done <= 1, go to IDLE; HI is skipped. Done arrives at cycle 2+CELL_LAT.
- Undefined: HI always runs; latency is fixed at 3+2*CELL_LAT.

## Structure
- Shared package sm_mcu_cpu_mul_pkg holds:
  - state enum (IDLE, LO, HI);
  - HALF_W=16;
  - CELL_LAT default.
- The cell is instantiated by the parent alongside this block; it is not a sub-module of it.
- No sub-module: one FSM plus datapath.

## Test plan
- src1=0x00012345, src2=0x00010003, CELL_LAT=1 -> done at cycle 5, result=0x234869CF.
- src1=0xFFFFFFFF, src2=0xFFFFFFFF -> result=0x00000001. Checks the mod-2^32 wrap in the HI accumulate.
- src1=7, src2=6 -> result=0x0000002A. Done at cycle 3 with SM_MCU_MUL_SHORTCUT_EN, cycle 5 without.
- Start pulsed in cycles 0, 2 and 5 with different operands -> the cycle-2 request is ignored. The cycle-5 request is accepted in the same cycle as done, and its result appears at cycle 10.
- Reset asserted in cycle 3 of an op -> next cycle busy=0, done=0, result=0. No done pulse follows. A new op afterward completes correctly.
- CELL_LAT=3 with a matching bench cell model, src1=0x80000000, src2=0x00020000 -> done at cycle 9, result=0x00000000.

Source files
------------

// File: rtl/sm_mcu_cpu_mul_pkg.sv
// ---------------------------------------------------------------------------
// sm_mcu_cpu_mul_pkg
// Shared definitions for the two-pass 32x32 multiply sequencer that sits in
// front of the CPU's 32x16 multiply cell.
//   - state_e       : sequencer FSM states (IDLE, LO, HI)
//   - DATA_W        : operand/result width (fixed at 32)
//   - HALF_W        : width of one multiplier half handed to the cell
//   - CELL_LAT_DEF  : default cell latency in cycles
//   - hi_accumulate : folds the high-half partial product into the low word
// ---------------------------------------------------------------------------
package sm_mcu_cpu_mul_pkg;

    localparam int DATA_W       = 32;
    localparam int HALF_W       = 16;
    localparam int CELL_LAT_DEF = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_e;

    // The high-half partial product is weighted by 2^16, so only its low
    // 16 bits can reach the low 32 bits of the full product. The addition
    // wraps mod 2^32 on purpose.
    function automatic logic [DATA_W-1:0] hi_accumulate(
        input logic [DATA_W-1:0] acc,
        input logic [DATA_W-1:0] cell_res
    );
        return acc + {cell_res[HALF_W-1:0], {HALF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/sm_mcu_cpu_mul_seq.sv
// ---------------------------------------------------------------------------
// sm_mcu_cpu_mul_seq
// Two-pass multiply sequencer. A 32x32 request is split into two passes
// through an external 32x16 multiply cell (low half of src2, then high half)
// and the low 32 bits of the product are returned with a one-cycle done.
// The low 32 bits are sign-agnostic, so there is no signed/unsigned control.
//
// Parameters:
//   CELL_LAT        cycles from stable cell operands to valid cell result (1..3)
//
// Ports:
//   clk             clock, all state on rising edge
//   reset           synchronous active-high reset
//   start           request strobe, accepted only while busy=0
//   src1, src2      operands, sampled on the accepted start
//   busy            high while an operation is in flight
//   done            one-cycle completion pulse, result valid
//   result          low 32 bits of src1*src2, held until next completion
//   mul_src1        cell operand A
//   mul_src2        cell operand B (cell uses [15:0] only)
//   mul_cell_result cell output, (mul_src1 * mul_src2[15:0]) mod 2^32
//
// Configuration macro:
//   SM_MCU_MUL_SHORTCUT_EN  when defined, skip the HI pass if src2[31:16]==0
// ---------------------------------------------------------------------------
module sm_mcu_cpu_mul_seq
    import sm_mcu_cpu_mul_pkg::*;
#(
    parameter int CELL_LAT = CELL_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] mul_src1,
    output logic [DATA_W-1:0] mul_src2,
    input  logic [DATA_W-1:0] mul_cell_result
);

    // Capture happens when the pass counter reaches the cell latency.
    localparam logic [1:0] CAP_CNT = 2'(CELL_LAT);

    state_e            state_q;
    logic [DATA_W-1:0] op1_q;
    logic [DATA_W-1:0] op2_q;
    logic [DATA_W-1:0] acc_q;
    logic [1:0]        cnt_q;
    // Selects which multiplier half is presented to the cell. It only changes
    // on acceptance and on entering HI, so the cell operands hold their last
    // value while IDLE and stay stable for the whole of each pass.
    logic              hi_sel_q;

    assign busy     = (state_q != IDLE);
    assign mul_src1 = op1_q;
    assign mul_src2 = {{HALF_W{1'b0}},
                       hi_sel_q ? op2_q[DATA_W-1:HALF_W] : op2_q[HALF_W-1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_sel_q <= 1'b0;
            result   <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op1_q    <= src1;
                        op2_q    <= src2;
                        cnt_q    <= '0;
                        hi_sel_q <= 1'b0;
                        state_q  <= LO;
                    end
                end
                LO: begin
                    if (cnt_q == CAP_CNT) begin
                        acc_q <= mul_cell_result;
                        cnt_q <= '0;
`ifdef SM_MCU_MUL_SHORTCUT_EN
                        // With a zero high half the low pass is already the answer.
                        if (op2_q[DATA_W-1:HALF_W] == '0) begin
                            result  <= mul_cell_result;
                            done    <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            hi_sel_q <= 1'b1;
                            state_q  <= HI;
                        end
`else
                        hi_sel_q <= 1'b1;
                        state_q  <= HI;
`endif
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                HI: begin
                    if (cnt_q == CAP_CNT) begin
                        result  <= hi_accumulate(acc_q, mul_cell_result);
                        done    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_mcu_cpu_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_sm_mcu_cpu_mul_seq
// Bench for the two-pass multiply sequencer. Two instances run side by side:
// one with CELL_LAT=1 and one with CELL_LAT=3, each with its own cell model.
// Expected results and completion cycles are queued at issue time and
// compared when done pulses.
// ---------------------------------------------------------------------------
module tb_sm_mcu_cpu_mul_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] res;
        int unsigned cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int unsigned a_free = 0;
    int unsigned b_free = 0;

    // ---------------- instance A, CELL_LAT = 1 ----------------
    logic        start_a = 1'b0;
    logic [31:0] src1_a = '0, src2_a = '0;
    logic        busy_a, done_a;
    logic [31:0] result_a, ms1_a, ms2_a;
    logic [31:0] cell_a = '0;

    sm_mcu_cpu_mul_seq #(.CELL_LAT(1)) dut_a (
        .clk(clk), .reset(rst), .start(start_a), .src1(src1_a), .src2(src2_a),
        .busy(busy_a), .done(done_a), .result(result_a),
        .mul_src1(ms1_a), .mul_src2(ms2_a), .mul_cell_result(cell_a)
    );

    always @(posedge clk) cell_a <= ms1_a * {16'h0, ms2_a[15:0]};

    // ---------------- instance B, CELL_LAT = 3 ----------------
    logic        start_b = 1'b0;
    logic [31:0] src1_b = '0, src2_b = '0;
    logic        busy_b, done_b;
    logic [31:0] result_b, ms1_b, ms2_b;
    logic [31:0] pb0 = '0, pb1 = '0, pb2 = '0;

    sm_mcu_cpu_mul_seq #(.CELL_LAT(3)) dut_b (
        .clk(clk), .reset(rst), .start(start_b), .src1(src1_b), .src2(src2_b),
        .busy(busy_b), .done(done_b), .result(result_b),
        .mul_src1(ms1_b), .mul_src2(ms2_b), .mul_cell_result(pb2)
    );

    always @(posedge clk) begin
        pb0 <= ms1_b * {16'h0, ms2_b[15:0]};
        pb1 <= pb0;
        pb2 <= pb1;
    end

    // Latency from start cycle to done cycle.
    function automatic int unsigned op_lat(input int unsigned l, input logic [31:0] s2);
`ifdef SM_MCU_MUL_SHORTCUT_EN
        if (s2[31:16] == 16'h0) return 2 + l;
`endif
        return 3 + 2 * l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one cycle; the model decides whether it is accepted.
    task automatic issue_a(input logic [31:0] s1, input logic [31:0] s2);
        exp_t e;
        start_a = 1'b1; src1_a = s1; src2_a = s2;
        if (cyc >= a_free) begin
            e.res = s1 * s2;
            e.cyc = cyc + op_lat(1, s2);
            qa.push_back(e);
            a_free = e.cyc;
        end
        tick();
        start_a = 1'b0;
    endtask

    task automatic issue_b(input logic [31:0] s1, input logic [31:0] s2);
        exp_t e;
        start_b = 1'b1; src1_b = s1; src2_b = s2;
        if (cyc >= b_free) begin
            e.res = s1 * s2;
            e.cyc = cyc + op_lat(3, s2);
            qb.push_back(e);
            b_free = e.cyc;
        end
        tick();
        start_b = 1'b0;
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (done_a) begin
                if (qa.size() == 0) begin
                    check_val("a_unexpected_done", 32'd1, 32'd0);
                end else begin
                    check_val("a_result", result_a, qa[0].res);
                    check_val("a_done_cycle", cyc, qa[0].cyc);
                    void'(qa.pop_front());
                end
            end else if (qa.size() != 0 && qa[0].cyc < cyc) begin
                check_val("a_missing_done", 32'd0, 32'd1);
                void'(qa.pop_front());
            end
            if (done_b) begin
                if (qb.size() == 0) begin
                    check_val("b_unexpected_done", 32'd1, 32'd0);
                end else begin
                    check_val("b_result", result_b, qb[0].res);
                    check_val("b_done_cycle", cyc, qb[0].cyc);
                    void'(qb.pop_front());
                end
            end else if (qb.size() != 0 && qb[0].cyc < cyc) begin
                check_val("b_missing_done", 32'd0, 32'd1);
                void'(qb.pop_front());
            end
        end
    end

    task automatic wait_idle(input int unsigned limit);
        for (int i = 0; i < limit; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            tick();
        end
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r1, r2;
        rst = 1'b1;
        repeat (3) tick();
        check_val("rst_busy_a", {31'd0, busy_a}, 32'd0);
        check_val("rst_done_a", {31'd0, done_a}, 32'd0);
        check_val("rst_result_a", result_a, 32'd0);
        check_val("rst_busy_b", {31'd0, busy_b}, 32'd0);
        check_val("rst_result_b", result_b, 32'd0);
        rst = 1'b0;
        tick();

        // Basic op, then busy during flight.
        issue_a(32'h0001_2345, 32'h0001_0003);
        check_val("busy_cycle1", {31'd0, busy_a}, 32'd1);
        wait_idle(20);

        issue_a(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(20);

        issue_a(32'd7, 32'd6);
        wait_idle(20);

        // Starts in cycles 0, 2 and 5: the middle one must be ignored.
        issue_a(32'h0002_0001, 32'h0003_0005);
        tick();
        issue_a(32'h1234_5678, 32'h0009_9999);
        tick();
        tick();
        issue_a(32'hDEAD_BEEF, 32'h0101_0101);
        wait_idle(30);

        // Reset mid-operation in cycle 3.
        issue_a(32'h5555_5555, 32'h0007_0003);
        tick();
        tick();
        rst = 1'b1;
        qa.delete();
        a_free = 0;
        tick();
        rst = 1'b0;
        check_val("midrst_busy", {31'd0, busy_a}, 32'd0);
        check_val("midrst_done", {31'd0, done_a}, 32'd0);
        check_val("midrst_result", result_a, 32'd0);
        repeat (8) tick();
        issue_a(32'h0000_ABCD, 32'h0002_0010);
        wait_idle(20);

        // CELL_LAT=3 instance.
        issue_b(32'h8000_0000, 32'h0002_0000);
        wait_idle(30);
        issue_b(32'h1357_9BDF, 32'h2468_ACE0);
        wait_idle(30);

        // Random traffic on both instances, including zero high halves.
        for (int i = 0; i < 40; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            if (($urandom % 3) == 0) r2[31:16] = 16'h0;
            if (($urandom % 2) == 0) begin
                start_b = (($urandom % 2) == 0);
                if (start_b) issue_b(r2, r1);
                else issue_a(r1, r2);
            end else begin
                tick();
            end
        end
        wait_idle(60);
        check_val("drain_a", qa.size(), 32'd0);
        check_val("drain_b", qb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
